// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the SRAM-like fetch/data bus arbiter:
// FSM state encoding, requester identities and access-size codes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Owner id doubles as the bit index into the {data, inst} request vector.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the fetch port, data port and downstream bus of the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface sram_like_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Handshake: a request is taken at the rising edge where req && addr_ok;
  // data_ok is a single-cycle completion pulse and rdata is valid only then.
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_addr_ok;
  logic          i_data_ok;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wr;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok;
  logic          d_data_ok;
  logic [DW-1:0] d_rdata;

  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/sram_like_arbiter_arb2_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time. Purely combinational.
module arb2_rr
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == OWN_INST) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one SRAM-like
// downstream bus, with exactly one transaction outstanding at a time.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  arb_if,
  output state_t              dbg_state
);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [1:0]    req_vec;
  logic [1:0]    grant;
  logic          done;

  // Arbitration only happens from IDLE; elsewhere nobody can win.
  assign req_vec = (state_q == ST_IDLE) ? {arb_if.d_req, arb_if.i_req} : 2'b00;

  arb2_rr u_arb (
    .req   (req_vec),
    .last  (last_owner_q),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant != 2'b00) state_d = ST_ADDR;
      ST_ADDR: if (arb_if.bus_addr_ok) state_d = arb_if.bus_data_ok ? ST_IDLE : ST_DATA;
      ST_DATA: if (arb_if.bus_data_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_INST;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      wdata_q      <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
    end
  end

  // Fetches are always word reads; the bus fields stay frozen between grants.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    if (grant[1]) begin
      owner_d      = OWN_DATA;
      last_owner_d = OWN_DATA;
      addr_d       = arb_if.d_addr;
      wr_d         = arb_if.d_wr;
      size_d       = arb_if.d_size;
      wdata_d      = arb_if.d_wdata;
    end else if (grant[0]) begin
      owner_d      = OWN_INST;
      last_owner_d = OWN_INST;
      addr_d       = arb_if.i_addr;
      wr_d         = 1'b0;
      size_d       = SZ_WORD;
      wdata_d      = '0;
    end
  end

  // Completion counts in DATA, or in ADDR when address and data are accepted together.
  assign done = ((state_q == ST_ADDR) && arb_if.bus_addr_ok && arb_if.bus_data_ok) ||
                ((state_q == ST_DATA) && arb_if.bus_data_ok);

  always_comb begin
    arb_if.i_addr_ok = resetn & grant[0];
    arb_if.d_addr_ok = resetn & grant[1];
    arb_if.i_data_ok = done & (owner_q == OWN_INST);
    arb_if.d_data_ok = done & (owner_q == OWN_DATA);
    arb_if.i_rdata   = arb_if.i_data_ok ? arb_if.bus_rdata : '0;
    arb_if.d_rdata   = arb_if.d_data_ok ? arb_if.bus_rdata : '0;
    arb_if.bus_req   = (state_q == ST_ADDR);
    arb_if.bus_wr    = wr_q;
    arb_if.bus_size  = size_q;
    arb_if.bus_addr  = addr_q;
    arb_if.bus_wdata = wdata_q;
    dbg_state        = state_q;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_sram_like_arbiter;
  import cpu_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 1 + 1 + 2 + AW + DW;

  typedef struct packed {
    logic          owner;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  logic checking = 1'b0;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.AW(AW), .DW(DW)) arb_if ();
  state_t dbg_state;

  sram_like_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .arb_if    (arb_if),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the outstanding transaction (empty = bus free).
  logic [TW-1:0] exp_q[$];
  logic          m_sent;
  logic          m_last;
  txn_t          m_fields;

  function automatic logic [1:0] m_pick(input logic ir, input logic dr, input logic busy,
                                        input logic last);
    if (busy) return 2'b00;
    if (ir && dr) return (last == OWN_DATA) ? 2'b01 : 2'b10;
    return {dr, ir};
  endfunction

  initial begin
    exp_q.delete();
    m_sent   = 1'b0;
    m_last   = OWN_INST;
    m_fields = '0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        exp_q.delete();
        m_sent   = 1'b0;
        m_last   = OWN_INST;
        m_fields = '0;
      end else begin
        logic busy, done;
        logic [1:0] pick;
        txn_t t;
        busy = (exp_q.size() != 0);
        pick = m_pick(arb_if.i_req, arb_if.d_req, busy, m_last);
        done = busy && arb_if.bus_data_ok && (m_sent || arb_if.bus_addr_ok);
        if (done) begin
          void'(exp_q.pop_front());
          m_sent = 1'b0;
        end else if (busy && arb_if.bus_addr_ok) begin
          m_sent = 1'b1;
        end
        if (pick != 2'b00) begin
          if (pick[1]) t = '{OWN_DATA, arb_if.d_wr, arb_if.d_size, arb_if.d_addr, arb_if.d_wdata};
          else         t = '{OWN_INST, 1'b0, SZ_WORD, arb_if.i_addr, {DW{1'b0}}};
          exp_q.push_back(t);
          m_last   = t.owner;
          m_fields = t;
          m_sent   = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic compare_all();
    logic busy, done, own;
    logic [1:0] pick;
    txn_t cur;
    if (!resetn) begin
      chk("rst_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd0);
      chk("rst_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd0);
      chk("rst_i_data_ok", 64'(arb_if.i_data_ok), 64'd0);
      chk("rst_d_data_ok", 64'(arb_if.d_data_ok), 64'd0);
      chk("rst_i_rdata",   64'(arb_if.i_rdata),   64'd0);
      chk("rst_d_rdata",   64'(arb_if.d_rdata),   64'd0);
      chk("rst_bus_req",   64'(arb_if.bus_req),   64'd0);
      chk("rst_bus_wr",    64'(arb_if.bus_wr),    64'd0);
      chk("rst_bus_size",  64'(arb_if.bus_size),  64'd0);
      chk("rst_bus_addr",  64'(arb_if.bus_addr),  64'd0);
      chk("rst_bus_wdata", 64'(arb_if.bus_wdata), 64'd0);
      return;
    end
    busy = (exp_q.size() != 0);
    cur  = busy ? txn_t'(exp_q[0]) : txn_t'('0);
    own  = cur.owner;
    pick = m_pick(arb_if.i_req, arb_if.d_req, busy, m_last);
    done = busy && arb_if.bus_data_ok && (m_sent || arb_if.bus_addr_ok);
    chk("cmp_i_addr_ok", 64'(arb_if.i_addr_ok), 64'(pick[0]));
    chk("cmp_d_addr_ok", 64'(arb_if.d_addr_ok), 64'(pick[1]));
    chk("cmp_i_data_ok", 64'(arb_if.i_data_ok), 64'(done && own == OWN_INST));
    chk("cmp_d_data_ok", 64'(arb_if.d_data_ok), 64'(done && own == OWN_DATA));
    chk("cmp_bus_req",   64'(arb_if.bus_req),   64'(busy && !m_sent));
    chk("cmp_bus_wr",    64'(arb_if.bus_wr),    64'(m_fields.wr));
    chk("cmp_bus_size",  64'(arb_if.bus_size),  64'(m_fields.size));
    chk("cmp_bus_addr",  64'(arb_if.bus_addr),  64'(m_fields.addr));
    chk("cmp_bus_wdata", 64'(arb_if.bus_wdata), 64'(m_fields.wdata));
    if (done && own == OWN_INST) chk("cmp_i_rdata", 64'(arb_if.i_rdata), 64'(arb_if.bus_rdata));
    if (done && own == OWN_DATA) chk("cmp_d_rdata", 64'(arb_if.d_rdata), 64'(arb_if.bus_rdata));
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (checking) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    arb_if.i_req       = 1'b0;
    arb_if.i_addr      = '0;
    arb_if.d_req       = 1'b0;
    arb_if.d_wr        = 1'b0;
    arb_if.d_size      = SZ_WORD;
    arb_if.d_addr      = '0;
    arb_if.d_wdata     = '0;
    arb_if.bus_addr_ok = 1'b0;
    arb_if.bus_data_ok = 1'b0;
    arb_if.bus_rdata   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rst_cnt;
    resetn = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    checking = 1'b1;

    // Requests during reset must not be granted.
    @(negedge clk); arb_if.i_req = 1'b1; arb_if.d_req = 1'b1; #3;
    chk("reset_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd0);
    chk("reset_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd0);
    chk("reset_state",     64'(dbg_state),        64'(ST_IDLE));
    @(negedge clk); clear_inputs(); resetn = 1'b1;

    // Fetch only, minimum latency.
    @(negedge clk); arb_if.i_req = 1'b1; arb_if.i_addr = 32'h1FC0_0000; #3;
    chk("fetch_c0_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd1);
    chk("fetch_c0_bus_req",   64'(arb_if.bus_req),   64'd0);
    @(negedge clk); arb_if.i_req = 1'b0; arb_if.bus_addr_ok = 1'b1; #3;
    chk("fetch_c1_bus_req",   64'(arb_if.bus_req),   64'd1);
    chk("fetch_c1_bus_addr",  64'(arb_if.bus_addr),  64'h1FC0_0000);
    chk("fetch_c1_bus_size",  64'(arb_if.bus_size),  64'(SZ_WORD));
    chk("fetch_c1_bus_wr",    64'(arb_if.bus_wr),    64'd0);
    @(negedge clk); arb_if.bus_addr_ok = 1'b0; arb_if.bus_data_ok = 1'b1;
    arb_if.bus_rdata = 32'h3C1D_0001; #3;
    chk("fetch_c2_i_data_ok", 64'(arb_if.i_data_ok), 64'd1);
    chk("fetch_c2_i_rdata",   64'(arb_if.i_rdata),   64'h3C1D_0001);
    chk("fetch_c2_d_data_ok", 64'(arb_if.d_data_ok), 64'd0);
    @(negedge clk); arb_if.bus_data_ok = 1'b0; #3;
    chk("fetch_c3_state",     64'(dbg_state),        64'(ST_IDLE));

    // Round-robin ties from a fresh reset; first completion is a combined addr/data accept.
    do_reset();
    @(negedge clk); arb_if.i_req = 1'b1; arb_if.d_req = 1'b1;
    arb_if.i_addr = 32'h200; arb_if.d_addr = 32'h100; #3;
    chk("tie1_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd1);
    chk("tie1_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd0);
    @(negedge clk); arb_if.d_req = 1'b0; arb_if.bus_addr_ok = 1'b1; arb_if.bus_data_ok = 1'b1;
    arb_if.bus_rdata = 32'h55; #3;
    chk("tie1_both_ok_d_data_ok", 64'(arb_if.d_data_ok), 64'd1);
    chk("tie1_both_ok_d_rdata",   64'(arb_if.d_rdata),   64'h55);
    chk("tie1_held_i_addr_ok",    64'(arb_if.i_addr_ok), 64'd0);
    @(negedge clk); arb_if.bus_addr_ok = 1'b0; arb_if.bus_data_ok = 1'b0; arb_if.d_req = 1'b1; #3;
    chk("tie2_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd1);
    chk("tie2_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd0);
    @(negedge clk); arb_if.i_req = 1'b0; arb_if.bus_addr_ok = 1'b1; #3;
    chk("tie2_bus_addr", 64'(arb_if.bus_addr), 64'h200);
    @(negedge clk); arb_if.bus_addr_ok = 1'b0; arb_if.bus_data_ok = 1'b1; #3;
    chk("tie2_i_data_ok", 64'(arb_if.i_data_ok), 64'd1);
    chk("tie2_busy_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd0);
    @(negedge clk); arb_if.bus_data_ok = 1'b0; arb_if.i_req = 1'b1; #3;
    chk("tie3_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd1);
    chk("tie3_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd0);
    @(negedge clk); arb_if.i_req = 1'b0; arb_if.d_req = 1'b0;
    arb_if.bus_addr_ok = 1'b1; arb_if.bus_data_ok = 1'b1; #3;
    chk("tie3_d_data_ok", 64'(arb_if.d_data_ok), 64'd1);
    @(negedge clk); arb_if.bus_addr_ok = 1'b0; #3;
    chk("spurious_idle_d_data_ok", 64'(arb_if.d_data_ok), 64'd0);
    chk("spurious_idle_i_data_ok", 64'(arb_if.i_data_ok), 64'd0);

    // Byte store held through three stalls (with an ignored data_ok in ADDR).
    @(negedge clk); arb_if.bus_data_ok = 1'b0; arb_if.d_req = 1'b1; arb_if.d_wr = 1'b1;
    arb_if.d_size = SZ_BYTE; arb_if.d_addr = 32'h8000_0003; arb_if.d_wdata = 32'hAB; #3;
    chk("store_d_addr_ok", 64'(arb_if.d_addr_ok), 64'd1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); arb_if.d_req = 1'b0; arb_if.d_wr = 1'b0; arb_if.d_addr = '0;
      arb_if.d_wdata = '0; arb_if.bus_data_ok = (s == 1); #3;
      chk("store_stall_bus_req",   64'(arb_if.bus_req),   64'd1);
      chk("store_stall_bus_wr",    64'(arb_if.bus_wr),    64'd1);
      chk("store_stall_bus_size",  64'(arb_if.bus_size),  64'(SZ_BYTE));
      chk("store_stall_bus_addr",  64'(arb_if.bus_addr),  64'h8000_0003);
      chk("store_stall_bus_wdata", 64'(arb_if.bus_wdata), 64'hAB);
      chk("store_stall_d_data_ok", 64'(arb_if.d_data_ok), 64'd0);
    end
    @(negedge clk); arb_if.bus_data_ok = 1'b0; arb_if.bus_addr_ok = 1'b1; #3;
    chk("store_accept_bus_req", 64'(arb_if.bus_req), 64'd1);
    @(negedge clk); arb_if.bus_addr_ok = 1'b0; arb_if.bus_data_ok = 1'b1; #3;
    chk("store_state_data", 64'(dbg_state),        64'(ST_DATA));
    chk("store_d_data_ok",  64'(arb_if.d_data_ok), 64'd1);
    @(negedge clk); arb_if.bus_data_ok = 1'b0; #3;
    chk("store_after_bus_req",  64'(arb_if.bus_req),  64'd0);
    chk("store_after_bus_addr", 64'(arb_if.bus_addr), 64'h8000_0003);

    // Reset while in DATA abandons the fetch; the held request is re-granted after release.
    @(negedge clk); arb_if.i_req = 1'b1; arb_if.i_addr = 32'h400; #3;
    chk("abort_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd1);
    @(negedge clk); arb_if.bus_addr_ok = 1'b1; #3;
    chk("abort_bus_req", 64'(arb_if.bus_req), 64'd1);
    @(negedge clk); arb_if.bus_addr_ok = 1'b0; #3;
    chk("abort_state_data", 64'(dbg_state), 64'(ST_DATA));
    @(negedge clk); resetn = 1'b0; arb_if.bus_data_ok = 1'b1; #3;
    chk("abort_rst_bus_req",   64'(arb_if.bus_req),   64'd0);
    chk("abort_rst_i_data_ok", 64'(arb_if.i_data_ok), 64'd0);
    chk("abort_rst_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd0);
    @(negedge clk); #3;
    chk("abort_rst2_i_data_ok", 64'(arb_if.i_data_ok), 64'd0);
    @(negedge clk); resetn = 1'b1; arb_if.bus_data_ok = 1'b0; #3;
    chk("abort_regrant_i_addr_ok", 64'(arb_if.i_addr_ok), 64'd1);

    // Randomized traffic with occasional mid-flight resets.
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst_cnt == 0 && $urandom_range(0, 299) == 0) rst_cnt = 2;
      resetn = (rst_cnt == 0);
      if (rst_cnt > 0) rst_cnt--;
      arb_if.i_req       = ($urandom_range(0, 2) != 0);
      arb_if.i_addr      = $urandom();
      arb_if.d_req       = ($urandom_range(0, 2) != 0);
      arb_if.d_wr        = $urandom_range(0, 1);
      arb_if.d_size      = 2'($urandom_range(0, 2));
      arb_if.d_addr      = $urandom();
      arb_if.d_wdata     = $urandom();
      arb_if.bus_addr_ok = ($urandom_range(0, 4) < 3);
      arb_if.bus_data_ok = ($urandom_range(0, 1) == 1);
      arb_if.bus_rdata   = $urandom();
    end

    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 i_req  in  1  instruction fetch request (read-only port).
REQ-006 i_addr  in  AW  fetch physical address.
REQ-007 i_addr_ok  out  1  fetch request accepted.
REQ-008 i_data_ok  out  1  fetch data returned.
REQ-009 i_rdata  out  DW  fetch read data.
REQ-010 d_req  in  1  data access request.
REQ-011 d_wr  in  1  1 = store, 0 = load.
REQ-012 d_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-013 d_addr  in  AW  data physical address.
REQ-014 d_wdata  in  DW  store data.
REQ-015 d_addr_ok  out  1  data request accepted.
REQ-016 d_data_ok  out  1  load data returned or store completed.
REQ-017 d_rdata  out  DW  load data.
REQ-018 bus_req  out  1  downstream request.
REQ-019 bus_wr  out  1  downstream write.
REQ-020 bus_size  out  2  downstream size.
REQ-021 bus_addr  out  AW  downstream address.
REQ-022 bus_wdata  out  DW  downstream write data.
REQ-023 bus_addr_ok  in  1  downstream accepted request.
REQ-024 bus_data_ok  in  1  downstream completion.
REQ-025 bus_rdata  in  DW  downstream read data.

Function
REQ-026 FSM states IDLE, ADDR, DATA; exactly one transaction outstanding at any time.
REQ-027 IDLE, one requester active: grant it; both active: grant the requester NOT granted last (round-robin via registered last_owner).
REQ-028 Granting cycle: drive winner's addr_ok = 1 combinationally; on the edge, latch owner, addr, wr, size, wdata; next state ADDR.
REQ-029 Fetch grant latches wr = 0, size = 2.
REQ-030 Loser's addr_ok = 0; its request stays pending, with no side effects.
REQ-031 addr_ok = 0 for both ports in ADDR and DATA.
REQ-032 ADDR: bus_req = 1 with latched fields; bus_addr_ok = 1 -> DATA.
REQ-033 Otherwise bus_req = 0; bus_* fields hold the last latched values.
REQ-034 DATA: bus_data_ok = 1 -> owner's data_ok = 1 same cycle; next state IDLE.
REQ-035 ADDR with bus_addr_ok and bus_data_ok both 1 -> owner's data_ok = 1; next state IDLE directly.
REQ-036 bus_data_ok in IDLE, or in ADDR without bus_addr_ok: ignored, no data_ok.
REQ-037 i_rdata = d_rdata = bus_rdata pass-through, valid only while the matching data_ok = 1.
REQ-038 Minimum latency with zero-wait downstream: grant cycle 0, bus_req cycle 1, data_ok cycle 2.
REQ-039 Stores complete with d_data_ok on bus_data_ok, same as loads.
REQ-040 New grant earliest in the cycle after data_ok (IDLE re-entry); no back-to-back overlap.

Reset
REQ-041 resetn = 0 forces: state IDLE, last_owner = INST (first tie goes to data), latched fields 0.
REQ-042 During reset, all outputs 0.
REQ-043 Reset mid-transaction abandons it: no data_ok issued; bus_req drops immediately (asynchronously).

Structure
REQ-044 Package cpu_bus_pkg holds: state encoding, owner constants OWN_INST/OWN_DATA, size codes SZ_BYTE/SZ_HALF/SZ_WORD.
REQ-045 One sub-module arb2_rr: combinational two-way round-robin picker (req[1:0], last -> grant[1:0]), instantiated once.

Verification
REQ-046 Fetch only: i_req = 1, i_addr = 0x1FC00000, bus_addr_ok 1 cycle later, bus_data_ok next with bus_rdata = 0x3C1D0001 -> i_addr_ok cycle 0, bus_req cycle 1, i_data_ok + i_rdata = 0x3C1D0001 cycle 2.
REQ-047 Tie after reset: i_req = d_req = 1 -> d_addr_ok first; after d_data_ok, i_addr_ok next grant; third tie grants data again.
REQ-048 Store: d_wr = 1, d_size = 0, d_addr = 0x80000003, d_wdata = 0xAB -> bus_wr = 1, bus_size = 0, bus_addr = 0x80000003, bus_wdata = 0xAB held through 3 stall cycles until bus_addr_ok.
REQ-049 Simultaneous bus_addr_ok and bus_data_ok in ADDR -> data_ok same cycle, IDLE next; spurious bus_data_ok in IDLE -> no data_ok.
REQ-050 resetn low while in DATA -> bus_req and data_ok stay 0; after release, pending i_req is re-granted with i_addr_ok.
